// File: rtl/serial_signed_add_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_signed_add_ctrl                                                     |
// | Signed W-bit adder built from one shared 4-bit slice, LSB slice first.      |
// | Optional build macro SERIAL_ADD_SATURATE_EN saturates overflowing results.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module serial_signed_add_ctrl #(
   parameter int N_SLICES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    arg_vld,
   output logic                    arg_rdy,
   input  logic [4*N_SLICES-1:0]   a,
   input  logic [4*N_SLICES-1:0]   b,
   output logic                    res_vld,
   input  logic                    res_rdy,
   output logic [4*N_SLICES-1:0]   sum,
   output logic                    overflow
);

   localparam int              c_w    = 4 * N_SLICES;
   localparam int              c_kw   = $clog2(N_SLICES);
   localparam logic [c_kw-1:0] c_last = c_kw'(N_SLICES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   logic [c_w-1:0]  r_a;
   logic [c_w-1:0]  r_b;
   logic [c_w-5:0]  r_acc;
   logic            r_carry;
   logic [c_kw-1:0] r_k;

   logic [4:0]      w_slice;
   logic [c_w-1:0]  w_next;
   logic            w_ovf;
   logic [c_w-1:0]  w_result;

   // Operands shift down one slice per cycle, so bit 3 of the final slice is the sign.
   assign w_slice = {1'b0, r_a[3:0]} + {1'b0, r_b[3:0]} + {4'b0000, r_carry};
   assign w_next  = {w_slice[3:0], r_acc};
   assign w_ovf   = (r_a[3] == r_b[3]) && (w_slice[3] != r_a[3]);

   always_comb begin
      w_result = w_next;
`ifdef SERIAL_ADD_SATURATE_EN
      if (w_ovf) begin
         w_result = r_a[3] ? {1'b1, {(c_w-1){1'b0}}} : {1'b0, {(c_w-1){1'b1}}};
      end
`else
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         arg_rdy  <= 1'b1;
         res_vld  <= 1'b0;
         sum      <= '0;
         overflow <= 1'b0;
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_carry  <= 1'b0;
         r_k      <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (arg_vld) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_carry <= 1'b0;
                  r_k     <= '0;
                  arg_rdy <= 1'b0;
                  r_state <= S_CALC;
               end
            end
            S_CALC: begin
               r_a     <= {4'b0000, r_a[c_w-1:4]};
               r_b     <= {4'b0000, r_b[c_w-1:4]};
               r_acc   <= w_next[c_w-1:4];
               r_carry <= w_slice[4];
               if (r_k == c_last) begin
                  // Final carry-out is dropped; only the W-bit result is kept.
                  r_k      <= '0;
                  sum      <= w_result;
                  overflow <= w_ovf;
                  res_vld  <= 1'b1;
                  r_state  <= S_DONE;
               end else begin
                  r_k <= r_k + 1'b1;
               end
            end
            S_DONE: begin
               if (res_rdy) begin
                  res_vld <= 1'b0;
                  arg_rdy <= 1'b1;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               arg_rdy <= 1'b1;
               res_vld <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_serial_signed_add_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_serial_signed_add_ctrl                                                  |
// | Vector table plus randomized operations against an arithmetic model.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_serial_signed_add_ctrl;

   localparam int N = 4;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         arg_vld = 1'b0;
   logic         arg_rdy;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         res_vld;
   logic         res_rdy = 1'b0;
   logic [W-1:0] sum;
   logic         overflow;

   int n_vec  = 0;
   int n_fail = 0;

   serial_signed_add_ctrl #(.N_SLICES(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .arg_vld  (arg_vld),
      .arg_rdy  (arg_rdy),
      .a        (a),
      .b        (b),
      .res_vld  (res_vld),
      .res_rdy  (res_rdy),
      .sum      (sum),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] s;
      logic         o;
   } vec_t;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", nm, got, exp);
      end
   endtask

   // Reference: exact integer sum, range-checked against the signed W-bit range.
   task automatic ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [W-1:0] s, output logic o);
      int t;
      t = int'($signed(x)) + int'($signed(y));
      o = (t > 32767) || (t < -32768);
      s = t[W-1:0];
`ifdef SERIAL_ADD_SATURATE_EN
      if (o) s = x[W-1] ? 16'h8000 : 16'h7FFF;
`endif
   endtask

   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic [W-1:0] es, input logic eo, input int hold);
      int           edges;
      logic [W-1:0] prev_s;
      logic         prev_o;
      logic [W-1:0] hs;
      logic         ho;
      edges = 0;
      while (!arg_rdy && edges < 20) begin
         @(negedge clk);
         edges++;
      end
      check("arg_rdy_idle", 32'(arg_rdy), 32'd1);
      prev_s  = sum;
      prev_o  = overflow;
      a       = ta;
      b       = tb_v;
      arg_vld = 1'b1;
      @(negedge clk);
      edges   = 0;
      arg_vld = 1'b0;
      a       = W'($urandom);
      b       = W'($urandom);
      check("arg_rdy_calc", 32'(arg_rdy), 32'd0);
      check("sum_hold_calc", 32'(sum), 32'(prev_s));
      check("ovf_hold_calc", 32'(overflow), 32'(prev_o));
      while (!res_vld && edges < 20) begin
         arg_vld = 1'($urandom);
         res_rdy = 1'($urandom);
         a       = W'($urandom);
         b       = W'($urandom);
         @(negedge clk);
         edges++;
      end
      check("latency", 32'(edges), 32'(N));
      res_rdy = 1'b0;
      hs      = sum;
      ho      = overflow;
      check("sum", 32'(sum), 32'(es));
      check("overflow", 32'(overflow), 32'(eo));
      repeat (hold) begin
         arg_vld = 1'($urandom);
         @(negedge clk);
         check("res_vld_hold", 32'(res_vld), 32'd1);
         check("arg_rdy_hold", 32'(arg_rdy), 32'd0);
         check("sum_hold", 32'(sum), 32'(hs));
         check("ovf_hold", 32'(overflow), 32'(ho));
      end
      arg_vld = 1'b0;
      res_rdy = 1'b1;
      @(negedge clk);
      res_rdy = 1'b0;
      check("res_vld_after_xfer", 32'(res_vld), 32'd0);
      check("arg_rdy_after_xfer", 32'(arg_rdy), 32'd1);
      check("sum_after_xfer", 32'(sum), 32'(hs));
   endtask

   vec_t         tbl[8];
   logic [W-1:0] ms;
   logic         mo;

   initial begin
      tbl[0] = '{16'h1234, 16'h0FFF, 16'h2233, 1'b0};
`ifdef SERIAL_ADD_SATURATE_EN
      tbl[1] = '{16'h7FFF, 16'h0001, 16'h7FFF, 1'b1};
      tbl[2] = '{16'h8000, 16'hFFFF, 16'h8000, 1'b1};
      tbl[5] = '{16'h4000, 16'h4000, 16'h7FFF, 1'b1};
`else
      tbl[1] = '{16'h7FFF, 16'h0001, 16'h8000, 1'b1};
      tbl[2] = '{16'h8000, 16'hFFFF, 16'h7FFF, 1'b1};
      tbl[5] = '{16'h4000, 16'h4000, 16'h8000, 1'b1};
`endif
      tbl[3] = '{16'hFFFF, 16'h0001, 16'h0000, 1'b0};
      tbl[4] = '{16'h8000, 16'h7FFF, 16'hFFFF, 1'b0};
      tbl[6] = '{16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0};
      tbl[7] = '{16'h0000, 16'h0000, 16'h0000, 1'b0};

      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("reset_arg_rdy", 32'(arg_rdy), 32'd1);
      check("reset_res_vld", 32'(res_vld), 32'd0);
      check("reset_sum", 32'(sum), 32'd0);
      check("reset_ovf", 32'(overflow), 32'd0);

      for (int i = 0; i < 8; i++) begin
         run_op(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].o, (i == 0) ? 5 : (i % 3));
      end

      // Abort in the second CALC cycle, then confirm no result appears.
      a       = 16'h1111;
      b       = 16'h2222;
      arg_vld = 1'b1;
      @(negedge clk);
      arg_vld = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_arg_rdy", 32'(arg_rdy), 32'd1);
      check("abort_res_vld", 32'(res_vld), 32'd0);
      check("abort_sum", 32'(sum), 32'd0);
      check("abort_ovf", 32'(overflow), 32'd0);
      repeat (6) begin
         @(negedge clk);
         check("abort_no_result", 32'(res_vld), 32'd0);
      end
      run_op(16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1);

      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         ra = W'($urandom);
         rb = W'($urandom);
         if (i % 5 == 0) ra = {ra[W-1], {(W-1){~ra[W-1]}}};
         ref_add(ra, rb, ms, mo);
         run_op(ra, rb, ms, mo, int'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/serial_signed_add_ctrl.md
SERIAL_SIGNED_ADD_CTRL -- requirements
Module: serial_signed_add_ctrl

Interface
REQ-001 The block SHALL have parameter N_SLICES, default 4, giving the number of 4-bit slices per operand; operand width W = 4*N_SLICES; legal range 2..16.
REQ-002 clk  input  1  Single clock; all state changes on its rising edge.
REQ-003 rst  input  1  Reset; synchronous, active-high.
REQ-004 arg_vld  input  1  Operand pair valid.
REQ-005 arg_rdy  output  1  Controller can accept an operand pair.
REQ-006 a  input  W  Signed two's-complement operand A.
REQ-007 b  input  W  Signed two's-complement operand B.
REQ-008 res_vld  output  1  Result valid.
REQ-009 res_rdy  input  1  Consumer accepts the result.
REQ-010 sum  output  W  Signed result.
REQ-011 overflow  output  1  Signed overflow flag for the W-bit addition.

Function
REQ-012 The block SHALL compute a+b on one shared 4-bit slice adder with carry-in, one slice per cycle, LSB slice first.
REQ-013 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-014 IDLE: arg_rdy=1 and res_vld=0; arg_vld=1 (the accept edge) captures a and b, clears the carry and slice counter, and moves to CALC.
REQ-015 CALC: arg_rdy=0 and res_vld=0; each cycle computes {carry, slice[k]} = a[k] + b[k] + carry into the result register, then increments k.
REQ-016 CALC: after slice N_SLICES-1, the FSM SHALL move to DONE; the slice counter SHALL wrap to 0 and SHALL never index beyond N_SLICES-1.
REQ-017 Overflow SHALL be computed on the top slice only: overflow = (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]); the final carry-out SHALL be discarded.
REQ-018 DONE: res_vld=1, and sum and overflow SHALL be held stable until the cycle in which res_rdy=1 (the result transfer).
REQ-019 DONE with res_rdy=1: the FSM SHALL return to IDLE; arg_rdy rises in the following cycle (no back-to-back accept in DONE).
REQ-020 Latency: res_vld SHALL first be high exactly N_SLICES cycles after the accept edge; throughput is at most one operation per N_SLICES+2 cycles.
REQ-021 arg_vld, a and b SHALL be ignored outside IDLE; changes to a or b after the accept edge SHALL NOT affect the result.
REQ-022 res_rdy SHALL be ignored outside DONE.
REQ-023 In IDLE and CALC, sum and overflow SHALL hold the last completed result (zero after reset).

Reset
REQ-024 rst=1 SHALL force IDLE on the next rising edge, from any state, aborting any operation in progress.
REQ-025 After reset: arg_rdy=1, res_vld=0, sum=0, overflow=0, carry=0, slice counter=0.
REQ-026 An aborted operation SHALL NOT produce a result.

Configuration
REQ-027 Macro SERIAL_ADD_SATURATE_EN: when defined, a result with overflow=1 SHALL be presented in DONE as the saturated value (0 1...1 if a[W-1]=0, 1 0...0 if a[W-1]=1); overflow stays 1.
REQ-028 Without SERIAL_ADD_SATURATE_EN, sum SHALL be the wrapped W-bit result; latency is identical in both builds.

Verification (N_SLICES=4)
REQ-029 a=0x1234, b=0x0FFF -> sum=0x2233, overflow=0; res_vld high 4 cycles after accept (carry propagates across slices).
REQ-030 a=0x7FFF, b=0x0001 -> overflow=1; sum=0x8000, or 0x7FFF with SERIAL_ADD_SATURATE_EN.
REQ-031 a=0x8000, b=0xFFFF -> overflow=1; sum=0x7FFF, or 0x8000 with SERIAL_ADD_SATURATE_EN.
REQ-032 a=0xFFFF, b=0x0001 -> sum=0x0000, overflow=0 (carry-out discarded); a=0x8000, b=0x7FFF -> sum=0xFFFF, overflow=0.
REQ-033 Hold res_rdy=0 for 5 cycles in DONE -> res_vld, sum and overflow remain stable and arg_rdy remains 0; arg_vld pulsed during CALC and DONE -> ignored.
REQ-034 Assert rst in the second CALC cycle -> next cycle arg_rdy=1, res_vld=0, sum=0; a new operand pair then completes correctly.
